stack_arb: RTL

- Shares one N-entry LIFO (external single-port SRAM) between R requesters.
- Arbitrates push/pop requests round-robin, granting at most one per cycle. Owns the stack pointer and occupancy, drives the SRAM ports, and returns pop data one cycle after grant.
- Sits between client pipelines and the stack memory; clients never touch the SRAM directly.

---
 rtl/stack_arb_pkg.sv | 19 +
 rtl/stack_arb_if.sv | 25 ++
 rtl/rr_arb.sv | 52 +++++
 rtl/stack_arb_chk.sv | 20 ++
 rtl/stack_arb.sv | 114 +++++++++++
 5 files changed

// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the stack arbiter: op encoding, default sizes,
// and the pop-response bundle.
package stack_arb_pkg;

    localparam int STACK_N    = 16;
    localparam int STACK_R    = 4;
    localparam int STACK_W    = 32;
    localparam int STACK_ID_W = $clog2(STACK_R);

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    // Response bundle, sized for the default requester count and data width
    typedef struct packed {
        logic [STACK_ID_W-1:0] id;
        logic [STACK_W-1:0]    data;
    } rsp_t;

endpackage

// File: rtl/stack_arb_if.sv
// Client-side request/response bus of the stack arbiter; master = clients,
// slave = arbiter.
interface stack_arb_if #(
    parameter int R    = 4,
    parameter int W    = 32,
    parameter int ID_W = $clog2(R)
);
    logic [R-1:0]    i_req_vld;
    logic [R-1:0]    i_req_op;
    logic [R*W-1:0]  i_req_data;
    logic [R-1:0]    o_req_rdy;
    logic            o_rsp_vld;
    logic [ID_W-1:0] o_rsp_id;
    logic [W-1:0]    o_rsp_data;

    modport master (
        output i_req_vld, i_req_op, i_req_data,
        input  o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_data
    );

    modport slave (
        input  i_req_vld, i_req_op, i_req_data,
        output o_req_rdy, o_rsp_vld, o_rsp_id, o_rsp_data
    );
endinterface

// File: rtl/rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner when the grant is taken.
module rr_arb #(
    parameter int R    = 4,
    parameter int ID_W = $clog2(R)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    i_req,
    input  logic            i_adv,
    output logic [R-1:0]    o_gnt,
    output logic [ID_W-1:0] o_gnt_idx
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic [ID_W-1:0] scan_idx_s;
    logic            found_s;

    // scan requesters starting at the pointer, first hit wins
    always_comb begin
        o_gnt      = '0;
        o_gnt_idx  = '0;
        found_s    = 1'b0;
        scan_idx_s = '0;
        for (int k = 0; k < R; k++) begin
            scan_idx_s = ID_W'((int'(ptr_q) + k) % R);
            if (!found_s && i_req[scan_idx_s]) begin
                found_s           = 1'b1;
                o_gnt[scan_idx_s] = 1'b1;
                o_gnt_idx         = scan_idx_s;
            end else begin
                found_s = found_s;
            end
        end
        if (i_adv && found_s) begin
            ptr_d = ID_W'((int'(o_gnt_idx) + 1) % R);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stack_arb_chk.sv
// Protocol properties of the stack arbiter: grant shape and SRAM access legality.
module stack_arb_chk #(
    parameter int R = 4
) (
    input logic         clk,
    input logic         rst,
    input logic [R-1:0] req_rdy,
    input logic         mem_wen,
    input logic         mem_ren,
    input logic         full,
    input logic         empty
);

    a_rdy_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_rdy));
    a_no_wen_full: assert property (@(posedge clk) disable iff (rst) !(mem_wen && full));
    a_no_ren_empty: assert property (@(posedge clk) disable iff (rst) !(mem_ren && empty));
    a_wen_ren_excl: assert property (@(posedge clk) disable iff (rst) !(mem_wen && mem_ren));
    a_full_empty_excl: assert property (@(posedge clk) disable iff (rst) !(full && empty));

endmodule

// File: rtl/stack_arb.sv
// Shares one LIFO in external single-port SRAM among R requesters: round-robin
// grant, stack pointer/occupancy, SRAM drive and one-cycle pop response.
module stack_arb
    import stack_arb_pkg::*;
#(
    parameter int N      = STACK_N,
    parameter int R      = STACK_R,
    parameter int W      = STACK_W,
    parameter int ADDR_W = $clog2(N),
    parameter int CNT_W  = $clog2(N + 1),
    parameter int ID_W   = $clog2(R)
) (
    input  logic              clk,
    input  logic              rst,
    stack_arb_if.slave        bus,
    output logic              o_mem_wen,
    output logic              o_mem_ren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [W-1:0]      o_mem_wdata,
    input  logic [W-1:0]      i_mem_rdata,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [R-1:0]     elig_s;
    logic [R-1:0]     gnt_s;
    logic [ID_W-1:0]  gnt_idx_s;
    logic             gnt_vld_s;
    logic             push_s;
    logic             pop_s;
    rsp_t             rsp_s;

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             rsp_vld_q, rsp_vld_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    // a request competes only if the stack can serve it this cycle
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < R; i++) begin
            elig_s[i] = bus.i_req_vld[i] &
                        ((bus.i_req_op[i] == OP_PUSH) ? ~full_q : ~empty_q);
        end
    end

    rr_arb #(.R(R), .ID_W(ID_W)) u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (elig_s),
        .i_adv     (gnt_vld_s),
        .o_gnt     (gnt_s),
        .o_gnt_idx (gnt_idx_s)
    );

    // grant decode, SRAM drive and next occupancy
    always_comb begin
        gnt_vld_s     = (|gnt_s) & ~rst;
        push_s        = gnt_vld_s & (bus.i_req_op[gnt_idx_s] == OP_PUSH);
        pop_s         = gnt_vld_s & (bus.i_req_op[gnt_idx_s] == OP_POP);
        bus.o_req_rdy = gnt_vld_s ? gnt_s : '0;
        o_mem_wen     = push_s;
        o_mem_ren     = pop_s;
        o_mem_addr    = '0;
        o_mem_wdata   = '0;
        count_d       = count_q;
        if (push_s) begin
            o_mem_addr  = count_q[ADDR_W-1:0];
            o_mem_wdata = bus.i_req_data[int'(gnt_idx_s)*W +: W];
            count_d     = count_q + CNT_W'(1);
        end else if (pop_s) begin
            o_mem_addr  = ADDR_W'(count_q - CNT_W'(1));
            count_d     = count_q - CNT_W'(1);
        end else begin
            count_d     = count_q;
        end
        full_d    = (count_d == CNT_W'(N));
        empty_d   = (count_d == CNT_W'(0));
        rsp_vld_d = pop_s;
        rsp_id_d  = pop_s ? gnt_idx_s : rsp_id_q;
    end

    // occupancy, flags and response tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    // SRAM read data arrives in the response cycle, so data passes straight through
    always_comb begin
        rsp_s.id       = rsp_id_q;
        rsp_s.data     = (rsp_vld_q & ~rst) ? i_mem_rdata : '0;
        bus.o_rsp_vld  = rsp_vld_q & ~rst;
        bus.o_rsp_id   = rsp_s.id;
        bus.o_rsp_data = rsp_s.data;
        o_count        = count_q;
        o_full         = full_q;
        o_empty        = empty_q;
    end

endmodule
